alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a four-state sequencer that drives an external 5-bit ALU.
// It captures each ALU result and returns it through a valid/ready handshake.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | FIFO empty, waiting for a command
// ISSUE | pop the FIFO head and register the ALU operands and select
// EXEC  | ALU inputs stable; alu_out is captured on exit
// RESP  | res_valid high, holding the result until res_ready
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_a,
  input  logic [4:0] cmd_b,
  input  logic       cmd_acc,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [4:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_data,
  output logic [1:0] res_op,
  output logic [7:0] op_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic       acc;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state;
  cmd_t            mem [FIFO_DEPTH];
  cmd_t            head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            empty;
  logic            push;
  logic            pop;
  logic [4:0]      acc_q;

  assign empty     = (count == '0);
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_ISSUE) && !empty;
  assign head      = mem[rd_ptr];

  // Storage is left unreset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, acc: cmd_acc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      acc_q     <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // acc_q was written when the previous EXEC ended, so no bubble is needed
          alu_a   <= head.acc ? acc_q : head.a;
          alu_b   <= head.b;
          alu_sel <= head.op;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_data  <= alu_out;
          acc_q     <= alu_out;
          res_op    <= alu_sel;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= empty ? ST_IDLE : ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 5-bit ALU.
// Expected values are hand-computed constants.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_a = '0;
  logic [4:0] cmd_b = '0;
  logic       cmd_acc = 1'b0;
  logic [4:0] alu_a;
  logic [4:0] alu_b;
  logic [1:0] alu_sel;
  logic [4:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [4:0] res_data;
  logic [1:0] res_op;
  logic [7:0] op_count;

  int tests = 0;
  int fails = 0;

  alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a + alu_b;
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int accepted;
    int seen;
    logic [1:0] f_op [6];
    logic [4:0] f_a  [6];
    logic [4:0] f_b  [6];
    logic [4:0] e_data [5];
    logic [1:0] e_op   [5];

    f_op[0] = 2'd1; f_a[0] = 5'd1;  f_b[0] = 5'd2;  e_data[0] = 5'd3;  e_op[0] = 2'd1;
    f_op[1] = 2'd2; f_a[1] = 5'd8;  f_b[1] = 5'd4;  e_data[1] = 5'd12; e_op[1] = 2'd2;
    f_op[2] = 2'd3; f_a[2] = 5'd15; f_b[2] = 5'd5;  e_data[2] = 5'd10; e_op[2] = 2'd3;
    f_op[3] = 2'd0; f_a[3] = 5'd6;  f_b[3] = 5'd3;  e_data[3] = 5'd2;  e_op[3] = 2'd0;
    f_op[4] = 2'd1; f_a[4] = 5'd30; f_b[4] = 5'd6;  e_data[4] = 5'd4;  e_op[4] = 2'd1;
    f_op[5] = 2'd1; f_a[5] = 5'd1;  f_b[5] = 5'd1;

    // reset values
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_op", res_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_op_count", op_count, 0);

    // basic ADD 7+9, accepted on the first edge after reset release
    rst_n = 1'b1;
    res_ready = 1'b1;
    send(2'd1, 5'd7, 5'd9, 1'b0);
    chk("add_valid_e0", res_valid, 0);
    step();
    step();
    chk("add_exec_sel", alu_sel, 1);
    chk("add_exec_a", alu_a, 7);
    chk("add_exec_b", alu_b, 9);
    chk("add_valid_e2", res_valid, 0);
    step();
    chk("add_valid_e3", res_valid, 1);
    chk("add_data", res_data, 16);
    chk("add_op", res_op, 1);
    chk("add_cnt_pre", op_count, 0);
    step();
    chk("add_cnt", op_count, 1);
    chk("add_valid_done", res_valid, 0);
    chk("add_hold_a", alu_a, 7);
    chk("add_hold_sel", alu_sel, 1);

    // wrap-around 20+15 = 35 mod 32
    send(2'd1, 5'd20, 5'd15, 1'b0);
    wait_valid(10, n);
    chk("wrap_latency", n, 3);
    chk("wrap_data", res_data, 3);
    step();
    chk("wrap_cnt", op_count, 2);

    // accumulator chain: 31 & 12, then acc ^ 5
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 5'd31; cmd_b = 5'd12; cmd_acc = 1'b0;
    step();
    cmd_op = 2'd3; cmd_a = 5'd0; cmd_b = 5'd5; cmd_acc = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_valid(10, n);
    chk("chain1_wait", n, 2);
    chk("chain1_data", res_data, 12);
    step();
    step();
    chk("chain2_exec_a", alu_a, 12);
    chk("chain2_exec_b", alu_b, 5);
    chk("chain2_exec_sel", alu_sel, 3);
    step();
    chk("chain2_valid", res_valid, 1);
    chk("chain2_data", res_data, 9);
    chk("chain2_op", res_op, 3);
    step();
    chk("chain_cnt", op_count, 4);

    // backpressure for three cycles
    res_ready = 1'b0;
    send(2'd1, 5'd1, 5'd2, 1'b0);
    wait_valid(10, n);
    chk("bp_latency", n, 3);
    chk("bp_data", res_data, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_data", res_data, 3);
    end
    chk("bp_cnt_stalled", op_count, 4);
    res_ready = 1'b1;
    step();
    chk("bp_valid_done", res_valid, 0);
    chk("bp_cnt", op_count, 5);
    step();
    chk("bp_cnt_once", op_count, 5);

    // FIFO full: six offered with the result stalled
    res_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = f_op[i]; cmd_a = f_a[i]; cmd_b = f_b[i]; cmd_acc = 1'b0;
      if (cmd_ready) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    chk("full_accepted", accepted, 5);
    chk("full_ready", cmd_ready, 0);
    chk("full_valid", res_valid, 1);
    step();
    step();
    chk("full_ready_hold", cmd_ready, 0);
    res_ready = 1'b1;
    chk("full_data0", res_data, e_data[0]);
    chk("full_op0", res_op, e_op[0]);
    for (int k = 1; k < 5; k++) begin
      step();
      wait_valid(10, n);
      chk("full_spacing", n, 2);
      chk("full_data", res_data, e_data[k]);
      chk("full_op", res_op, e_op[k]);
    end
    step();
    chk("full_cnt", op_count, 10);
    chk("full_ready_after", cmd_ready, 1);

    // reset while in EXEC with two commands queued
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 5'd1; cmd_b = 5'd1; cmd_acc = 1'b0;
    step();
    cmd_a = 5'd2;
    step();
    cmd_a = 5'd3;
    step();
    cmd_valid = 1'b0;
    chk("rexec_alu_a", alu_a, 1);
    rst_n = 1'b0;
    #1;
    chk("rexec_valid", res_valid, 0);
    chk("rexec_ready", cmd_ready, 1);
    chk("rexec_cnt", op_count, 0);
    chk("rexec_alu_a0", alu_a, 0);
    chk("rexec_data", res_data, 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (res_valid) seen = 1;
    end
    chk("rexec_no_stale", seen, 0);
    chk("rexec_cnt_after", op_count, 0);

    // accumulator cleared by reset: acc + 5 = 5
    send(2'd1, 5'd0, 5'd5, 1'b1);
    wait_valid(10, n);
    chk("acc_rst_latency", n, 3);
    chk("acc_rst_data", res_data, 5);
    step();
    chk("acc_rst_cnt", op_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
